// File: rtl/dmem_responder.sv
// Data-memory responder: dimage loader plus big-endian
// byte/half/word load and store port with error flags.
module dmem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int ADDR_W      = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_valid,
   input  logic [31:0]       load_data,
   output logic              load_ready,
   output logic              load_done,
   output logic              load_trunc,
   output logic [31:0]       sp_init,
   input  logic [ADDR_W-1:0] RAddr_d,
   input  logic              Ren,
   input  logic [1:0]        RSize,
   input  logic              RSigned,
   output logic [31:0]       Rdata_d,
   input  logic              Wen,
   input  logic [1:0]        WSize,
   input  logic [ADDR_W-1:0] WAddr_d,
   input  logic [31:0]       Wdata_d,
   output logic              misalign,
   output logic              addr_overflow
);

   localparam int IDX_W = ADDR_W - 2;

   typedef enum logic [1:0] {
      HDR_SP, HDR_CNT, DATA, RUN
   } ld_state_t;

   ld_state_t   state, state_n;
   logic [31:0] count;
   logic [31:0] wp;
   logic [31:0] mem [DEPTH_WORDS];

   logic        hs, run;
   logic        ld_wr;

   assign load_ready = (state != RUN);
   assign load_done  = (state == RUN);
   assign run        = (state == RUN);
   assign hs         = load_valid & load_ready;
   assign ld_wr      = hs & (state == DATA)
                     & (wp < 32'(DEPTH_WORDS));

   always_comb begin
      state_n = state;
      if (hs) begin
         unique case (state)
            HDR_SP:  state_n = HDR_CNT;
            HDR_CNT: state_n = (load_data == 32'd0)
                             ? RUN : DATA;
            DATA:    state_n = (count == 32'd1)
                             ? RUN : DATA;
            default: state_n = RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= HDR_SP;
         count      <= '0;
         wp         <= '0;
         sp_init    <= '0;
         load_trunc <= 1'b0;
      end else begin
         state <= state_n;
         if (hs) begin
            unique case (state)
               HDR_SP: sp_init <= load_data;
               HDR_CNT: begin
                  count <= load_data;
                  wp    <= '0;
               end
               DATA: begin
                  count <= count - 32'd1;
                  wp    <= wp + 32'd1;
                  if (!ld_wr)
                     load_trunc <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   // Byte count minus one; sizes 10 and 11 are words.
   function automatic logic [ADDR_W:0] last_off(
      input logic [1:0] sz
   );
      unique case (1'b1)
         (sz == 2'b00): last_off = (ADDR_W+1)'(0);
         (sz == 2'b01): last_off = (ADDR_W+1)'(1);
         default:       last_off = (ADDR_W+1)'(3);
      endcase
   endfunction

   function automatic logic is_mis(
      input logic [1:0]        sz,
      input logic [ADDR_W-1:0] a
   );
      unique case (1'b1)
         (sz == 2'b00): is_mis = 1'b0;
         (sz == 2'b01): is_mis = a[0];
         default:       is_mis = (a[1:0] != 2'b00);
      endcase
   endfunction

   logic [ADDR_W:0] rd_end, wr_end;
   logic            rd_mis, rd_ovf, wr_mis, wr_ovf;
   logic            rd_ok, wr_ok;

   assign rd_end = {1'b0, RAddr_d} + last_off(RSize);
   assign wr_end = {1'b0, WAddr_d} + last_off(WSize);
   assign rd_ovf = rd_end[ADDR_W];
   assign wr_ovf = wr_end[ADDR_W];
   assign rd_mis = is_mis(RSize, RAddr_d);
   assign wr_mis = is_mis(WSize, WAddr_d);
   assign rd_ok  = run & Ren & ~rd_mis & ~rd_ovf;
   assign wr_ok  = run & Wen & ~wr_mis & ~wr_ovf;

   logic [31:0] rd_word, rd_val;
   logic [7:0]  rd_b;
   logic [15:0] rd_h;

   assign rd_word = mem[RAddr_d[ADDR_W-1:2]];

   always_comb begin
      rd_b = 8'h00;
      unique case (RAddr_d[1:0])
         2'd0: rd_b = rd_word[31:24];
         2'd1: rd_b = rd_word[23:16];
         2'd2: rd_b = rd_word[15:8];
         default: rd_b = rd_word[7:0];
      endcase
      rd_h = RAddr_d[1] ? rd_word[15:0]
                        : rd_word[31:16];
      unique case (1'b1)
         (RSize == 2'b00):
            rd_val = {{24{RSigned & rd_b[7]}}, rd_b};
         (RSize == 2'b01):
            rd_val = {{16{RSigned & rd_h[15]}}, rd_h};
         default:
            rd_val = rd_word;
      endcase
   end

   logic [3:0]  wmask;
   logic [31:0] wbytes;

   always_comb begin
      unique case (1'b1)
         (WSize == 2'b00): begin
            wbytes = {4{Wdata_d[7:0]}};
            wmask  = 4'b1000 >> WAddr_d[1:0];
         end
         (WSize == 2'b01): begin
            wbytes = {2{Wdata_d[15:0]}};
            wmask  = WAddr_d[1] ? 4'b0011 : 4'b1100;
         end
         default: begin
            wbytes = Wdata_d;
            wmask  = 4'b1111;
         end
      endcase
   end

   // Array is never reset so a mid-load reset keeps prior words.
   always_ff @(posedge clk) begin
      if (ld_wr) begin
         mem[wp[IDX_W-1:0]] <= load_data;
      end else if (wr_ok) begin
         for (int i = 0; i < 4; i++)
            if (wmask[i])
               mem[WAddr_d[ADDR_W-1:2]][i*8 +: 8]
                  <= wbytes[i*8 +: 8];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         Rdata_d       <= '0;
         misalign      <= 1'b0;
         addr_overflow <= 1'b0;
      end else begin
         if (rd_ok)
            Rdata_d <= rd_val;
         misalign      <= run & ((Ren & rd_mis)
                                | (Wen & wr_mis));
         addr_overflow <= run & ((Ren & rd_ovf)
                                | (Wen & wr_ovf));
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: image load,
// sized loads/stores, error pulses and mid-load reset.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_valid;
   logic [31:0] load_data;
   logic        load_ready, load_done, load_trunc;
   logic [31:0] sp_init;
   logic [9:0]  RAddr_d, WAddr_d;
   logic        Ren, RSigned, Wen;
   logic [1:0]  RSize, WSize;
   logic [31:0] Rdata_d, Wdata_d;
   logic        misalign, addr_overflow;

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] sb[$];

   always #5 clk = ~clk;

   dmem_responder dut (
      .clk(clk), .rst(rst),
      .load_valid(load_valid), .load_data(load_data),
      .load_ready(load_ready), .load_done(load_done),
      .load_trunc(load_trunc), .sp_init(sp_init),
      .RAddr_d(RAddr_d), .Ren(Ren), .RSize(RSize),
      .RSigned(RSigned), .Rdata_d(Rdata_d),
      .Wen(Wen), .WSize(WSize), .WAddr_d(WAddr_d),
      .Wdata_d(Wdata_d), .misalign(misalign),
      .addr_overflow(addr_overflow)
   );

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h",
                  tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #12;
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   task automatic send(input logic [31:0] w);
      int t = 0;
      load_valid = 1'b1;
      load_data  = w;
      while (!load_ready && t < 20) begin
         @(posedge clk); #1; t++;
      end
      if (t >= 20) chk("ready_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      load_valid = 1'b0;
   endtask

   task automatic rd(input logic [9:0] a,
                     input logic [1:0] sz,
                     input logic sg,
                     input logic [31:0] exp,
                     input logic em, input logic eo);
      RAddr_d = a; RSize = sz; RSigned = sg;
      Ren = 1'b1;
      sb.push_back(exp);
      @(posedge clk); #1;
      Ren = 1'b0;
      chk("rdata", Rdata_d, sb.pop_front());
      chk("rd_mis", 32'(misalign), 32'(em));
      chk("rd_ovf", 32'(addr_overflow), 32'(eo));
   endtask

   task automatic wr(input logic [9:0] a,
                     input logic [1:0] sz,
                     input logic [31:0] d,
                     input logic em, input logic eo);
      WAddr_d = a; WSize = sz; Wdata_d = d;
      Wen = 1'b1;
      @(posedge clk); #1;
      Wen = 1'b0;
      chk("wr_mis", 32'(misalign), 32'(em));
      chk("wr_ovf", 32'(addr_overflow), 32'(eo));
   endtask

   initial begin
      load_valid = 0; load_data = 0;
      RAddr_d = 0; Ren = 0; RSize = 0; RSigned = 0;
      WAddr_d = 0; Wen = 0; WSize = 0; Wdata_d = 0;
      rst = 1'b1;
      #3;
      do_reset();

      chk("rst_ready", 32'(load_ready), 32'd1);
      chk("rst_done", 32'(load_done), 32'd0);
      chk("rst_trunc", 32'(load_trunc), 32'd0);
      chk("rst_sp", sp_init, 32'd0);
      chk("rst_rdata", Rdata_d, 32'd0);
      chk("rst_flags",
          32'({misalign, addr_overflow}), 32'd0);

      // requests during load must be ignored
      Ren = 1'b1; RAddr_d = 10'h001; RSize = 2'b10;
      send(32'h0000_0400);
      send(32'h0000_0002);
      send(32'h1122_3344);
      chk("pre_run_rdata", Rdata_d, 32'd0);
      chk("pre_run_mis", 32'(misalign), 32'd0);
      chk("pre_done", 32'(load_done), 32'd0);
      Ren = 1'b0;
      send(32'hAABB_CCDD);
      chk("done", 32'(load_done), 32'd1);
      chk("ready_run", 32'(load_ready), 32'd0);
      chk("sp_init", sp_init, 32'h400);

      rd(10'h004, 2'b10, 1'b0, 32'hAABBCCDD, 0, 0);
      rd(10'h003, 2'b00, 1'b1, 32'h00000044, 0, 0);
      rd(10'h000, 2'b00, 1'b0, 32'h00000011, 0, 0);
      rd(10'h004, 2'b00, 1'b1, 32'hFFFFFFAA, 0, 0);
      rd(10'h002, 2'b01, 1'b1, 32'h00003344, 0, 0);
      wr(10'h001, 2'b00, 32'h000000FF, 0, 0);
      rd(10'h000, 2'b10, 1'b0, 32'h11FF3344, 0, 0);
      wr(10'h002, 2'b01, 32'h0000BEEF, 0, 0);
      rd(10'h002, 2'b01, 1'b0, 32'h0000BEEF, 0, 0);
      rd(10'h002, 2'b01, 1'b1, 32'hFFFFBEEF, 0, 0);
      rd(10'h3FE, 2'b10, 1'b0, 32'hFFFFBEEF, 1, 1);
      rd(10'h3FF, 2'b01, 1'b0, 32'hFFFFBEEF, 1, 1);
      wr(10'h002, 2'b10, 32'h01234567, 1, 0);
      rd(10'h000, 2'b11, 1'b0, 32'h11FFBEEF, 0, 0);

      // read-first on same-cycle collision
      wr(10'h010, 2'b10, 32'h0, 0, 0);
      WAddr_d = 10'h010; WSize = 2'b10;
      Wdata_d = 32'hDEADBEEF; Wen = 1'b1;
      rd(10'h010, 2'b10, 1'b0, 32'h0, 0, 0);
      Wen = 1'b0;
      rd(10'h010, 2'b10, 1'b0, 32'hDEADBEEF, 0, 0);

      // truncated image
      do_reset();
      chk("rst2_done", 32'(load_done), 32'd0);
      send(32'h0000_0200);
      send(32'h0000_0101);
      for (int i = 0; i < 257; i++)
         send(32'hA000_0000 | 32'(i));
      chk("trunc", 32'(load_trunc), 32'd1);
      chk("trunc_done", 32'(load_done), 32'd1);
      rd(10'h000, 2'b10, 1'b0, 32'hA0000000, 0, 0);
      rd(10'h3FC, 2'b10, 1'b0, 32'hA00000FF, 0, 0);
      rd(10'h200, 2'b10, 1'b0, 32'hA0000080, 0, 0);

      // reset in the middle of a load
      do_reset();
      chk("rst3_trunc", 32'(load_trunc), 32'd0);
      send(32'h0000_0300);
      send(32'h0000_0003);
      send(32'h5555_AAAA);
      chk("mid_done", 32'(load_done), 32'd0);
      do_reset();
      send(32'h0000_0800);
      send(32'h0000_0001);
      chk("re_pre_done", 32'(load_done), 32'd0);
      send(32'hCAFE_F00D);
      chk("re_done", 32'(load_done), 32'd1);
      chk("re_sp", sp_init, 32'h800);
      rd(10'h000, 2'b10, 1'b0, 32'hCAFEF00D, 0, 0);
      rd(10'h004, 2'b10, 1'b0, 32'hA0000001, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
